// File: rtl/mult_seq_ctrl.sv
// Shift-and-add unsigned multiplier sequencer. Borrows the shared datapath adder
// through add_op1/add_op2/add_sum and retires one multiplier bit per cycle.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [WIDTH-1:0]   add_op1,
  output logic [WIDTH-1:0]   add_op2,
  input  logic [WIDTH-1:0]   add_sum,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q, acc_hi_q, acc_lo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic             carry;

  // The adder wraps mod 2^WIDTH, so a wrapped sum is smaller than either operand.
  assign carry = (add_sum < acc_hi_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_RUN;
            mcand_q  <= multiplicand;
            acc_lo_q <= multiplier;
            acc_hi_q <= '0;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end
          done_q <= 1'b0;
        end
        S_RUN: begin
          if (acc_lo_q[0])
            {acc_hi_q, acc_lo_q} <= {carry, add_sum, acc_lo_q[WIDTH-1:1]};
          else
            {acc_hi_q, acc_lo_q} <= {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign add_op1 = acc_hi_q;
  assign add_op2 = mcand_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {acc_hi_q, acc_lo_q};

endmodule
